saw_period_meter: RTL and testbench
===================================

SAW_PERIOD_METER -- requirements
Module: saw_period_meter

Interface
REQ-001 Parameter DATA_W, default 8, width of the sampled sawtooth value.
REQ-002 Parameter DEPTH, default 4, record FIFO depth; power of two, minimum 2.
REQ-003 Parameter PER_W, default 9, width of the period field; saturates at 2^PER_W-1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 ena  input  1  measurement enable; low forces IDLE.
REQ-007 sample_in  input  DATA_W  sawtooth sample from the upstream counter stage, one per cycle.
REQ-008 ovf_clr  input  1  single-cycle pulse; clears the overflow flag.
REQ-009 out_ready  input  1  consumer accepts the head record.
REQ-010 out_valid  output  1  head record present (FIFO not empty).
REQ-011 out_peak  output  DATA_W  head record: maximum sample seen in the period.
REQ-012 out_period  output  PER_W  head record: period length in cycles.
REQ-013 fifo_level  output  clog2(DEPTH)+1  number of stored records.
REQ-014 overflow  output  1  sticky flag; a record was dropped.

Function
REQ-015 The block SHALL register sample_in into prev_sample every cycle; wrap event = (sample_in == 0) AND (prev_sample != 0).
REQ-016 FSM states SHALL be IDLE, SYNC, MEASURE.
REQ-017 IDLE -> SYNC when ena=1; any state -> IDLE when ena=0, clearing count and peak; FIFO contents and overflow are retained.
REQ-018 SYNC -> MEASURE on a wrap event, loading count=1, peak=0; no record is pushed on this first wrap.
REQ-019 In MEASURE on a non-wrap cycle: count <= count+1, saturating at 2^PER_W-1; peak <= max(peak, sample_in), unsigned.
REQ-020 In MEASURE on a wrap cycle: push {peak, count}, then reload count=1, peak=0; remain in MEASURE.
REQ-021 Period definition: cycles from one wrap cycle up to, but not including, the next; sequence 0,1,2,3,0 yields period 4, peak 3.
REQ-022 A constant sample_in of 0 SHALL never produce a wrap; count saturates and no record is produced.
REQ-023 A pushed record SHALL appear at the FIFO head with out_valid=1 on the cycle after the wrap cycle when the FIFO was empty.
REQ-024 A pop SHALL occur when out_valid AND out_ready; out_peak and out_period SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 Push to a full FIFO with no simultaneous pop SHALL drop the new record and set overflow; existing entries are unchanged.
REQ-026 Simultaneous push and pop when full SHALL both succeed, and fifo_level stays at DEPTH.
REQ-027 Simultaneous push and pop when empty SHALL push only; out_valid rises the next cycle.
REQ-028 ovf_clr SHALL clear overflow, except when a drop occurs in the same cycle, in which case overflow stays set.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; fifo_level SHALL never exceed DEPTH.

Reset
REQ-030 rst_n low SHALL immediately force: state=IDLE, prev_sample=0, count=0, peak=0, FIFO empty, out_valid=0, fifo_level=0, overflow=0.
REQ-031 out_peak and out_period SHALL read 0 while the FIFO is empty after reset.
REQ-032 Reset asserted mid-period SHALL discard the partial measurement; after release the block SHALL pass through SYNC again before producing any record.

Structure
REQ-033 A shared package saw_meter_pkg SHALL hold the state enum (IDLE/SYNC/MEASURE), the record struct {peak, period}, and the constants DATA_W_DEF=8 and PER_W_DEF=9.
REQ-034 The FIFO SHALL be a sub-module, rec_fifo (parameterised width/depth, valid/ready pop, full/empty/level), instantiated once.

Verification
REQ-035 ena=1, sample 0,1,2,3,0,1,2,3,0 repeating, out_ready=1 -> first record {peak 3, period 4} one cycle after the second wrap; every later record is identical.
REQ-036 Constant sample_in=0 for 600 cycles with ena=1 -> no wrap, out_valid stays 0, count saturates at 511.
REQ-037 Sawtooth period 3 (0,1,2), out_ready=0 for 6 wraps -> fifo_level=4, overflow=1 after the 5th post-sync record; the first 4 records are intact on drain.
REQ-038 FIFO full with out_ready=1 on a wrap cycle -> level stays 4, no overflow; ovf_clr pulse -> overflow returns to 0.
REQ-039 rst_n pulsed low mid-period, with sample_in at 2 of 0..5 -> all outputs 0 asynchronously; the first record after release comes only after one SYNC wrap plus one full period {5, 6}.
REQ-040 ena dropped for 3 cycles mid-period -> no partial record; stored records remain poppable; measurement resumes via SYNC.

Source files
------------

// File: rtl/saw_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : saw_meter_pkg
//  Description : Shared types and constants for the sawtooth period meter:
//                measurement state encoding, record layout and default
//                widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package saw_meter_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int PER_W_DEF  = 9;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        MEASURE = 2'd2
    } meter_state_t;

    // One record at the default widths. The FIFO stores records packed in
    // this same order, {peak, period}, at whatever widths the top is given.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] peak;
        logic [PER_W_DEF-1:0]  period;
    } meter_rec_t;

endpackage : saw_meter_pkg
`default_nettype wire

// File: rtl/rec_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rec_fifo
//  Description : Small synchronous record FIFO with valid/ready pop side.
//                A push is accepted when not full, or when full and a pop
//                happens in the same cycle. Depth must be a power of two
//                (>= 2) so the pointers wrap on their natural width.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                push, push_data     - write request and record
//                pop_ready           - consumer takes head record
//                pop_valid, pop_data - head present / head record (raw)
//                full, empty, level  - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module rec_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop_ready,
    output logic                     pop_valid,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL_LVL = (c_PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_level;
    logic               w_pop;
    logic               w_push_ok;

    assign empty     = (r_level == '0);
    assign full      = (r_level == c_FULL_LVL);
    assign pop_valid = ~empty;
    assign level     = r_level;
    assign pop_data  = r_mem[r_rd_ptr];

    assign w_pop     = pop_valid & pop_ready;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign w_push_ok = push & (~full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: the head is only meaningful while not empty.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
    end

endmodule : rec_fifo
`default_nettype wire

// File: rtl/saw_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : saw_period_meter
//  Description : Measures the period and peak of a sawtooth sample stream.
//                A wrap is a sample of 0 following a non-zero sample. After
//                one synchronising wrap, each following wrap closes a period
//                and pushes {peak, period} into a record FIFO.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                ena                   - measurement enable
//                sample_in             - sawtooth sample, one per cycle
//                ovf_clr               - clears the sticky overflow flag
//                out_ready/out_valid   - record handshake
//                out_peak, out_period  - head record (0 when empty)
//                fifo_level            - stored record count
//                overflow              - sticky, a record was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module saw_period_meter
    import saw_meter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int PER_W  = PER_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [DATA_W-1:0]        sample_in,
    input  logic                     ovf_clr,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_peak,
    output logic [PER_W-1:0]         out_period,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int               c_REC_W   = DATA_W + PER_W;
    localparam logic [PER_W-1:0] c_PER_MAX = '1;

    meter_state_t        r_state;
    meter_state_t        w_state_nxt;
    logic [DATA_W-1:0]   r_prev_sample;
    logic [DATA_W-1:0]   r_peak;
    logic [DATA_W-1:0]   w_peak_nxt;
    logic [PER_W-1:0]    r_count;
    logic [PER_W-1:0]    w_count_nxt;
    logic [PER_W-1:0]    w_count_inc;
    logic                r_overflow;
    logic                w_wrap;
    logic                w_push;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;
    logic [c_REC_W-1:0]  w_push_rec;
    logic [c_REC_W-1:0]  w_head_rec;

    assign w_wrap      = (sample_in == '0) && (r_prev_sample != '0);
    assign w_count_inc = (r_count == c_PER_MAX) ? r_count : r_count + 1'b1;
    assign w_push_rec  = {r_peak, r_count};

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_peak_nxt  = r_peak;
        w_push      = 1'b0;
        if (!ena) begin
            // Abandon any partial period; stored records are untouched.
            w_state_nxt = IDLE;
            w_count_nxt = '0;
            w_peak_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = SYNC;
                end
                SYNC: begin
                    if (w_wrap) begin
                        w_state_nxt = MEASURE;
                        w_count_nxt = PER_W'(1);
                        w_peak_nxt  = '0;
                    end else begin
                        // Keep counting while waiting so a stuck-at-zero
                        // input shows up as a saturated count.
                        w_count_nxt = w_count_inc;
                    end
                end
                MEASURE: begin
                    if (w_wrap) begin
                        w_push      = 1'b1;
                        w_count_nxt = PER_W'(1);
                        w_peak_nxt  = '0;
                    end else begin
                        w_count_nxt = w_count_inc;
                        w_peak_nxt  = (sample_in > r_peak) ? sample_in : r_peak;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // A record is lost only when full and the consumer is not popping.
    assign w_drop = w_push & w_full & ~(out_valid & out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_prev_sample <= '0;
            r_count       <= '0;
            r_peak        <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_prev_sample <= sample_in;
            r_count       <= w_count_nxt;
            r_peak        <= w_peak_nxt;
            // A drop in the same cycle as a clear wins.
            r_overflow    <= w_drop | (r_overflow & ~ovf_clr);
        end
    end

    rec_fifo #(
        .WIDTH (c_REC_W),
        .DEPTH (DEPTH)
    ) u_rec_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_rec),
        .pop_ready (out_ready),
        .pop_valid (out_valid),
        .pop_data  (w_head_rec),
        .full      (w_full),
        .empty     (w_empty),
        .level     (fifo_level)
    );

    // Storage is not reset, so force a clean zero head while empty.
    assign out_peak   = w_empty ? '0 : w_head_rec[c_REC_W-1 -: DATA_W];
    assign out_period = w_empty ? '0 : w_head_rec[PER_W-1:0];
    assign overflow   = r_overflow;

endmodule : saw_period_meter
`default_nettype wire

// File: tb/tb_saw_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_saw_period_meter
//  Description : Directed self-checking bench for saw_period_meter with
//                hand-computed expected records.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_saw_period_meter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] sample_in = 8'd0;
    logic       ovf_clr = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_peak;
    logic [8:0] out_period;
    logic [2:0] fifo_level;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    saw_period_meter #(
        .DATA_W (8),
        .DEPTH  (4),
        .PER_W  (9)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .sample_in  (sample_in),
        .ovf_clr    (ovf_clr),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_peak   (out_peak),
        .out_period (out_period),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_head(input string tag, input int peak, input int period);
        check_val({tag, "_valid"},  32'(out_valid),  1);
        check_val({tag, "_peak"},   32'(out_peak),   peak);
        check_val({tag, "_period"}, 32'(out_period), period);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_valid"},  32'(out_valid),  0);
        check_val({tag, "_level"},  32'(fifo_level), 0);
        check_val({tag, "_peak"},   32'(out_peak),   0);
        check_val({tag, "_period"}, 32'(out_period), 0);
        check_val({tag, "_ovf"},    32'(overflow),   0);
    endtask

    // Called and returns at posedge+1; inputs then hold across the next edge.
    task automatic tick(input logic [7:0] s);
        sample_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        ena = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0; sample_in = 8'd0;
        #2 rst_n = 1'b0;
        #1 check_idle_outputs(tag);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Period-3 sawtooth whose peak grows per period: 0,1,p+1.
    function automatic logic [7:0] saw3(input int k);
        int ph;
        ph = k % 3;
        if (ph == 0)      return 8'd0;
        else if (ph == 1) return 8'd1;
        else              return 8'((k / 3) + 1);
    endfunction

    initial begin
        int bad;
        int exp_pk [4];

        // ---------------- reset state ----------------
        do_reset("reset");

        // ---------------- period 4, always ready ----------------
        ena = 1'b1; out_ready = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            tick(8'(k % 4));
            if (k >= 8 && (k % 4) == 0) check_head("saw4_rec", 3, 4);
            else check_val("saw4_novalid", 32'(out_valid), 0);
        end

        // ---------------- constant zero ----------------
        do_reset("reset2");
        ena = 1'b1;
        bad = 0;
        for (int k = 0; k < 600; k++) begin
            tick(8'd0);
            if (out_valid) bad++;
        end
        check_val("zero_valid_seen", 32'(bad), 0);
        check_val("zero_level", 32'(fifo_level), 0);
        check_val("zero_count_sat", 32'(dut.r_count), 511);

        // ---------------- fill, overflow, clear ----------------
        do_reset("reset3");
        ena = 1'b1; out_ready = 1'b0;
        for (int k = 0; k <= 18; k++) begin
            tick(saw3(k));
            if (k == 15) begin
                check_val("fill_level4", 32'(fifo_level), 4);
                check_val("fill_noovf", 32'(overflow), 0);
            end
        end
        check_val("drop_level", 32'(fifo_level), 4);
        check_val("drop_ovf", 32'(overflow), 1);
        check_head("drop_head", 2, 3);
        ovf_clr = 1'b1; tick(saw3(19)); ovf_clr = 1'b0;
        check_val("clr_ovf", 32'(overflow), 0);
        tick(saw3(20));
        out_ready = 1'b1; tick(saw3(21)); out_ready = 1'b0;
        check_val("pushpop_full_level", 32'(fifo_level), 4);
        check_val("pushpop_full_ovf", 32'(overflow), 0);
        tick(saw3(22));
        tick(saw3(23));
        ovf_clr = 1'b1; tick(saw3(24)); ovf_clr = 1'b0;
        check_val("drop_vs_clr_ovf", 32'(overflow), 1);
        check_val("drop_vs_clr_level", 32'(fifo_level), 4);
        ena = 1'b0;
        tick(8'd0);
        check_head("hold_a", 3, 3);
        tick(8'd0);
        check_head("hold_b", 3, 3);
        exp_pk = '{3, 4, 5, 7};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_head("drain", exp_pk[i], 3);
            tick(8'd0);
        end
        check_val("drain_valid", 32'(out_valid), 0);
        check_val("drain_level", 32'(fifo_level), 0);
        check_val("drain_peak0", 32'(out_peak), 0);
        check_val("drain_period0", 32'(out_period), 0);
        check_val("drain_ovf_kept", 32'(overflow), 1);

        // ---------------- async reset mid-period ----------------
        do_reset("reset4");
        ena = 1'b1; out_ready = 1'b0;
        for (int k = 0; k <= 14; k++) tick(8'(k % 6));
        check_head("pre_rst_rec", 5, 6);
        check_val("pre_rst_level", 32'(fifo_level), 1);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int j = 0; j <= 9; j++) begin
            tick(8'((3 + j) % 6));
            if (j == 9) check_head("post_rst_rec", 5, 6);
            else check_val("post_rst_novalid", 32'(out_valid), 0);
        end

        // ---------------- enable dropped mid-period ----------------
        out_ready = 1'b0;
        for (int j = 10; j <= 17; j++) tick(8'((3 + j) % 6));
        check_val("ena_pre_level", 32'(fifo_level), 2);
        ena = 1'b0;
        tick(8'((3 + 18) % 6));
        out_ready = 1'b1; tick(8'((3 + 19) % 6)); out_ready = 1'b0;
        tick(8'((3 + 20) % 6));
        check_val("ena_low_pop_level", 32'(fifo_level), 1);
        ena = 1'b1;
        bad = 0;
        for (int j = 21; j <= 32; j++) begin
            tick(8'((3 + j) % 6));
            if (fifo_level != 3'd1) bad++;
        end
        check_val("ena_resync_nopush", 32'(bad), 0);
        tick(8'((3 + 33) % 6));
        check_val("ena_resume_level", 32'(fifo_level), 2);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check_head("ena_drain", 5, 6);
            tick(8'd0);
        end
        check_val("ena_drain_empty", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule : tb_saw_period_meter
`default_nettype wire
